// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_shift_add_multiplier_pkg;

  // Controller states; encoding 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Step counter width: one extra bit above clog2 so SIZE itself is representable.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/cascade_adder.sv
// Ripple-carry adder: sum/carry-out of a + b + carry-in, one full-adder cell per bit.
module cascade_adder #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            c,
  output logic [SIZE-1:0] sum,
  output logic            k
);

  // Carry ripples LSB to MSB through a local variable to keep the chain acyclic.
  always_comb begin
    logic cy;
    sum = '0;
    cy  = c;
    for (int i = 0; i < int'(SIZE); i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    k = cy;
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier: p = a * b, one partial product per cycle.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*SIZE-1:0] p
);

  localparam int unsigned     CntW     = cnt_width(SIZE);
  localparam logic [CntW-1:0] LastStep = CntW'(SIZE - 1);

  state_e              state_q, state_d;
  logic [SIZE-1:0]     m_q, m_d;
  logic [SIZE-1:0]     acc_q, acc_d;
  logic [SIZE-1:0]     q_q, q_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*SIZE-1:0]   p_q, p_d;

  logic [SIZE-1:0]     add_b;
  logic [SIZE-1:0]     sum;
  logic                k;
  logic [2*SIZE-1:0]   shifted;

  // Partial product: add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    add_b = q_q[0] ? m_q : '0;
  end

  cascade_adder #(
    .SIZE (SIZE)
  ) u_adder (
    .a   (acc_q),
    .b   (add_b),
    .c   (1'b0),
    .sum (sum),
    .k   (k)
  );

  // Right shift of {k, sum, q}: carry lands in the top of acc, q[0] is consumed.
  always_comb begin
    shifted = {k, sum, q_q[SIZE-1:1]};
  end

  // Next-state, datapath updates and outputs.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy  = 1'b1;
        acc_d = shifted[2*SIZE-1:SIZE];
        q_d   = shifted[SIZE-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          p_d     = shifted;
          state_d = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including the held product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench: driver pushes a*b and expected done cycle, monitors pop on done.
module tb_seq_shift_add_multiplier;

  typedef struct {
    logic [15:0] prod;
    int          dcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b1;
  int   cyc = 0;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  exp_t q4[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic [15:0] hold_p4 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  seq_shift_add_multiplier #(.SIZE(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .p     (p4)
  );

  seq_shift_add_multiplier #(.SIZE(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .p     (p8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for the SIZE=4 instance: busy window, done timing, product and hold.
  always begin : mon4
    exp_t e;
    logic exp_busy;
    @(negedge clk);
    #2;
    if (rst_seen) begin
      chk("rst busy4", {31'd0, busy4}, 32'd0);
      chk("rst done4", {31'd0, done4}, 32'd0);
      chk("rst p4", {24'd0, p4}, 32'd0);
      hold_p4 = '0;
    end else begin
      exp_busy = (q4.size() > 0) && (cyc >= q4[0].dcyc - 4);
      chk("busy4", {31'd0, busy4}, {31'd0, exp_busy});
      if (done4) begin
        if (q4.size() == 0) begin
          chk("done4 with nothing pending", {31'd0, done4}, 32'd0);
        end else begin
          e = q4.pop_front();
          chk("p4 at done", {24'd0, p4}, {16'd0, e.prod});
          chk("done4 cycle", cyc, e.dcyc);
          hold_p4 = e.prod;
        end
      end else begin
        chk("p4 hold", {24'd0, p4}, {16'd0, hold_p4});
        if (q4.size() > 0 && cyc > q4[0].dcyc) begin
          chk("done4 missing", {31'd0, done4}, 32'd1);
          void'(q4.pop_front());
        end
      end
    end
  end

  // Monitor for the SIZE=8 instance: product and done timing.
  always begin : mon8
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst_seen) begin
      if (done8) begin
        if (q8.size() == 0) begin
          chk("done8 with nothing pending", {31'd0, done8}, 32'd0);
        end else begin
          e = q8.pop_front();
          chk("p8 at done", {16'd0, p8}, {16'd0, e.prod});
          chk("done8 cycle", cyc, e.dcyc);
          chk("busy8 at done", {31'd0, busy8}, 32'd1);
        end
      end else if (q8.size() > 0 && cyc > q8[0].dcyc) begin
        chk("done8 missing", {31'd0, done8}, 32'd1);
        void'(q8.pop_front());
      end
    end
  end

  task automatic wait_idle4();
    int n = 0;
    while (busy4 !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle4 timeout", {31'd0, busy4}, 32'd0);
  endtask

  task automatic issue4(input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    wait_idle4();
    a4 = x;
    b4 = y;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    e.prod = 16'(x) * 16'(y);
    e.dcyc = cyc + 4;
    q4.push_back(e);
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int n = 0;
    while (busy8 !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("idle8 timeout", {31'd0, busy8}, 32'd0);
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    e.prod = 16'(x) * 16'(y);
    e.dcyc = cyc + 8;
    q8.push_back(e);
  endtask

  initial begin : main
    exp_t e;
    int   c0;
    int   n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    issue4(4'd3, 4'd5);
    issue4(4'd15, 4'd15);
    issue4(4'd0, 4'd13);
    issue4(4'd13, 4'd0);

    // start held high: second op accepted SIZE+2 cycles after the first.
    wait_idle4();
    a4 = 4'd7;
    b4 = 4'd6;
    start4 = 1'b1;
    @(negedge clk);
    c0 = cyc;
    e.prod = 16'd42;
    e.dcyc = c0 + 4;
    q4.push_back(e);
    a4 = 4'd2;
    b4 = 4'd2;
    e.prod = 16'd4;
    e.dcyc = c0 + 10;
    q4.push_back(e);
    while (cyc < c0 + 6) @(negedge clk);
    start4 = 1'b0;

    // Reset mid-run aborts without a done pulse, then a fresh op completes.
    issue4(4'd9, 4'd9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q4.delete();
    rst = 1'b0;
    @(negedge clk);
    issue4(4'd9, 4'd9);

    // start and rst together: reset wins, nothing accepted.
    wait_idle4();
    rst = 1'b1;
    start4 = 1'b1;
    a4 = 4'd5;
    b4 = 4'd5;
    @(negedge clk);
    rst = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue4(4'($urandom), 4'($urandom));
    end

    n = 0;
    while (q4.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("q4 drained", q4.size(), 32'd0);

    // Wider instance.
    issue8(8'd255, 8'd255);
    for (int i = 0; i < 5; i++) issue8(8'($urandom), 8'($urandom));
    n = 0;
    while (q8.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("q8 drained", q8.size(), 32'd0);

    repeat (2) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
